shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Sequencing controller for a WIDTH-bit shift register built from cascaded mc10141 universal shift registers, as used in the KL10 datapath. It accepts a single command over a valid/ready handshake: load, or shift N places in either direction with a selectable fill. For each command it drives the 2-bit mode select shared by all chips, and drives the serial fill inputs at both ends of the chain. It reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 36, total bits in the chain, MSB-first (bit 0 = leftmost chip q[0]).
- `CNT_W`, 6, width of the shift-count field.
- `clk`  in  1  single clock, shared with the mc10141 chain.
- `resetN`  in  1  asynchronous, active-low reset.
- `cmdValid`  in  1  command offered.
- `cmdReady`  out  1  controller accepts a command this cycle.
- `cmdOp`  in  2  command op: 0=LOAD, 1=SHL (toward bit WIDTH-1), 2=SHR (toward bit 0), 3=NOP.
- `cmdCount`  in  CNT_W  number of shift places (ignored for LOAD/NOP).
- `cmdFill`  in  2  fill source: 0=ZERO, 1=ONE, 2=SIGN, 3=ROT.
- `abort`  in  1  synchronous cancel of the command in progress.
- `qMsb`  in  1  chain bit 0 (feedback).
- `qLsb`  in  1  chain bit WIDTH-1 (feedback).
- `modeSel`  out  2  to all chips' s[1:0]: 00 LOAD, 01 SHIFTL, 10 SHIFTR, 11 HOLD.
- `d0Fill`  out  1  to leftmost chip d0In (enters bit 0 in SHIFTL mode).
- `d3Fill`  out  1  to rightmost chip d3In (enters bit WIDTH-1 in SHIFTR mode).
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOADING, SHIFTING, DONE.
- IDLE:
  - `cmdReady`=1, `modeSel`=HOLD.
  - On `cmdValid`, latch `cmdOp`/`cmdCount`/`cmdFill`.
  - LOAD → LOADING.
  - SHL/SHR with count>0 → SHIFTING, remaining counter = count.
  - NOP, or any shift with count=0 → DONE.
- LOADING: `modeSel`=LOAD for exactly one cycle → DONE.
- SHIFTING:
  - `modeSel`=SHIFTL for SHL, SHIFTR for SHR.
  - Remaining counter decrements each cycle; when remaining==1 at the clock edge → DONE.
- DONE: `done`=1, `modeSel`=HOLD, `cmdReady`=0 → IDLE.
- `busy` = state != IDLE.
- `abort`:
  - In LOADING or SHIFTING → IDLE at the next edge; no `done`.
  - Ignored in IDLE and DONE.
  - Shifts already clocked are not undone.
- Fill, combinational from the latched fill source and live `qMsb`/`qLsb`:
  - SHL `d0Fill`: ZERO→0, ONE→1, SIGN→`qMsb`, ROT→`qLsb`.
  - SHR `d3Fill`: ZERO→0, ONE→1, SIGN→0, ROT→`qMsb`.
  - The unused end's fill, and both fills outside SHIFTING, are 0.
- Counts ≥ WIDTH are legal and shift that many places (ROT with count=WIDTH returns the original word).

## Timing
- Reset values: state IDLE, `modeSel`=11, `cmdReady`=1, `busy`=0, `done`=0, `d0Fill`=0, `d3Fill`=0, counter 0, latched command cleared.
- `modeSel`, `busy`, `cmdReady` and `done` are decoded from registered state only (Moore), so the chain sees them stable for the whole cycle.
- Handshake edge E0 = first edge with `cmdValid`&&`cmdReady`.
- Shift of N: the chain shifts at edges E1..EN; `done` is high in the cycle after EN; `cmdReady`=1 one cycle after that. Throughput is N+2 cycles.
- LOAD: chain loads at E1; `done` in the following cycle. NOP/count 0: `done` in the cycle after E0; `modeSel` never leaves HOLD.
- `cmdValid` while `cmdReady`=0 is ignored, never queued.
- Abort asserted in the cycle before edge Ek (k<N): the chain has shifted k times; `modeSel`=HOLD from the cycle after Ek.
- `resetN` low mid-command: all outputs take reset values immediately (asynchronous); the latched command is discarded.

## Test plan
All scenarios run against a 36-bit chain of 9 mc10141 models.
- Reset: assert `resetN`=0 mid-shift → `modeSel`=11, `cmdReady`=1, `busy`=0, `done`=0, both fills 0 without waiting for a clock.
- LOAD 0x123456789 → exactly one cycle of `modeSel`=00; q=0x123456789; `done` pulses the next cycle; q holds after.
- SHL count 4 ZERO on 0x800000000 → exactly 4 cycles of `modeSel`=01; q=0x080000000; `done` in cycle E5.
- SHL count 3 SIGN on 0x800000000 → q=0xF00000000. SHR count 1 ROT on 0x800000001 → q=0x000000003. SHR count 36 ROT → original word.
- NOP and SHL count 0 → `modeSel` stays 11; `done` one cycle after accept; q unchanged.
- SHR count 10 ONE on 0, abort before E3 → q=0x000000007; no `done`; `cmdReady`=1 the next cycle; `cmdValid` held during busy not accepted.

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_sequencer: command sequencer for a cascaded mc10141 shift chain |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_sequencer #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdOp,
    input  logic [CNT_W-1:0] cmdCount,
    input  logic [1:0]       cmdFill,
    input  logic             abort,
    input  logic             qMsb,
    input  logic             qLsb,
    output logic [1:0]       modeSel,
    output logic             d0Fill,
    output logic             d3Fill,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_loading  = 2'd1;
    localparam logic [1:0] c_st_shifting = 2'd2;
    localparam logic [1:0] c_st_done     = 2'd3;

    localparam logic [1:0] c_op_load = 2'd0;
    localparam logic [1:0] c_op_shl  = 2'd1;
    localparam logic [1:0] c_op_shr  = 2'd2;

    localparam logic [1:0] c_fill_zero = 2'd0;
    localparam logic [1:0] c_fill_one  = 2'd1;
    localparam logic [1:0] c_fill_sign = 2'd2;

    localparam logic [1:0] c_mode_load   = 2'b00;
    localparam logic [1:0] c_mode_shiftl = 2'b01;
    localparam logic [1:0] c_mode_shiftr = 2'b10;
    localparam logic [1:0] c_mode_hold   = 2'b11;

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // Shift counts are independent of chain length; a degenerate chain is simply not sequenced differently.
    if (WIDTH < 1) begin : g_width_degenerate
    end

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_op;
    logic [1:0]       r_fill;
    logic             w_accept;

    assign w_accept = (r_state == c_st_idle) && cmdValid;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= c_st_idle;
            r_count <= c_cnt_zero;
            r_op    <= 2'd0;
            r_fill  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op    <= cmdOp;
                r_count <= cmdCount;
                r_fill  <= cmdFill;
            end else if ((r_state == c_st_shifting) && (r_count != c_cnt_zero)) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (cmdValid) begin
                    case (cmdOp)
                        c_op_load: w_next_state = c_st_loading;
                        c_op_shl,
                        c_op_shr:  w_next_state = (cmdCount == c_cnt_zero) ? c_st_done : c_st_shifting;
                        default:   w_next_state = c_st_done;
                    endcase
                end
            end
            c_st_loading:  w_next_state = abort ? c_st_idle : c_st_done;
            // Abort wins over the final-shift transition, so an aborted command never reports done.
            c_st_shifting: begin
                if (abort) begin
                    w_next_state = c_st_idle;
                end else if (r_count == c_cnt_one) begin
                    w_next_state = c_st_done;
                end
            end
            default:       w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        modeSel  = c_mode_hold;
        cmdReady = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        d0Fill   = 1'b0;
        d3Fill   = 1'b0;
        case (r_state)
            c_st_idle: begin
                cmdReady = 1'b1;
                busy     = 1'b0;
            end
            c_st_loading: modeSel = c_mode_load;
            c_st_shifting: begin
                if (r_op == c_op_shl) begin
                    modeSel = c_mode_shiftl;
                    case (r_fill)
                        c_fill_zero: d0Fill = 1'b0;
                        c_fill_one:  d0Fill = 1'b1;
                        c_fill_sign: d0Fill = qMsb;
                        default:     d0Fill = qLsb;
                    endcase
                end else begin
                    modeSel = c_mode_shiftr;
                    case (r_fill)
                        c_fill_one:  d3Fill = 1'b1;
                        2'd3:        d3Fill = qMsb;
                        default:     d3Fill = 1'b0;
                    endcase
                end
            end
            default: done = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [1:0]  cmdOp = 2'd0;
    logic [5:0]  cmdCount = 6'd0;
    logic [1:0]  cmdFill = 2'd0;
    logic        abort = 1'b0;
    logic [1:0]  modeSel;
    logic        d0Fill, d3Fill, busy, done;
    logic [35:0] q = 36'd0;
    logic [35:0] load_data = 36'd0;

    shift_sequencer #(.WIDTH(36), .CNT_W(6)) dut (
        .clk(clk), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdCount(cmdCount), .cmdFill(cmdFill), .abort(abort),
        .qMsb(q[35]), .qLsb(q[0]), .modeSel(modeSel), .d0Fill(d0Fill),
        .d3Fill(d3Fill), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Nine mc10141 chips as one word: chain bit 0 is q[35], chain bit 35 is q[0].
    always @(posedge clk) begin
        case (modeSel)
            2'b00: q <= load_data;
            2'b01: q <= {d0Fill, q[35:1]};
            2'b10: q <= {q[34:0], d3Fill};
            default: q <= q;
        endcase
    end

    typedef struct {
        int          mode;
        int          fill;
        logic [35:0] exp_q;
        bit          exp_done;
        int          exp_lat;
        int          exp_modes;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [35:0] model_q = 36'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Whole-command result from the shift rules, without stepping per cycle.
    function automatic logic [35:0] ref_shift(logic [35:0] w, int op, int fill, int n);
        logic [35:0] all1;
        logic [71:0] t;
        logic [35:0] res;
        int r;
        all1 = '1;
        r = n % 36;
        if (op == 1) begin
            if (fill == 3) begin
                t = {w, w} >> r;
                res = t[35:0];
            end else begin
                res = (n >= 36) ? 36'd0 : (w >> n);
                if (fill == 1 || (fill == 2 && w[35]))
                    res = res | ((n >= 36) ? all1 : ~(all1 >> n));
            end
        end else begin
            if (fill == 3) begin
                t = {w, w} << r;
                res = t[71:36];
            end else begin
                res = (n >= 36) ? 36'd0 : (w << n);
                if (fill == 1)
                    res = res | ((n >= 36) ? all1 : ~(all1 << n));
            end
        end
        return res;
    endfunction

    // Monitor
    bit in_flight = 0;
    int lat = 0;
    int mode_cnt = 0;
    always @(negedge clk) begin
        if (!resetN) begin
            sb.delete();
            in_flight = 0;
        end else begin
            if (modeSel == 2'b01) begin
                chk("d0_fill_shl", 64'(d0Fill), (sb.size() == 0) ? 64'd0 :
                    64'((sb[0].fill == 1) ? 1'b1 : (sb[0].fill == 2) ? q[35] :
                        (sb[0].fill == 3) ? q[0] : 1'b0));
                chk("d3_fill_shl", 64'(d3Fill), 64'd0);
            end else if (modeSel == 2'b10) begin
                chk("d3_fill_shr", 64'(d3Fill), (sb.size() == 0) ? 64'd0 :
                    64'((sb[0].fill == 1) ? 1'b1 : (sb[0].fill == 3) ? q[35] : 1'b0));
                chk("d0_fill_shr", 64'(d0Fill), 64'd0);
            end else begin
                chk("fills_idle", 64'({d0Fill, d3Fill}), 64'd0);
            end
            if (in_flight && sb.size() > 0) begin
                lat++;
                if (modeSel != 2'b11) begin
                    mode_cnt++;
                    chk("mode_value", 64'(modeSel), 64'(sb[0].mode));
                end
                if (done) begin
                    chk("done_expected", 64'(1), 64'(sb[0].exp_done));
                    chk("done_latency", 64'(lat), 64'(sb[0].exp_lat));
                    chk("done_mode_cycles", 64'(mode_cnt), 64'(sb[0].exp_modes));
                    chk("done_q", 64'(q), 64'(sb[0].exp_q));
                    chk("done_flags", 64'({cmdReady, busy, modeSel}), 64'(4'b0111));
                    void'(sb.pop_front());
                    in_flight = 0;
                end else if (!busy) begin
                    chk("abort_no_done", 64'(0), 64'(sb[0].exp_done));
                    chk("abort_latency", 64'(lat), 64'(sb[0].exp_lat));
                    chk("abort_mode_cycles", 64'(mode_cnt), 64'(sb[0].exp_modes));
                    chk("abort_q", 64'(q), 64'(sb[0].exp_q));
                    chk("abort_ready", 64'(cmdReady), 64'd1);
                    void'(sb.pop_front());
                    in_flight = 0;
                end else if (lat > 80) begin
                    chk("cmd_timeout", 64'(lat), 64'(sb[0].exp_lat));
                    void'(sb.pop_front());
                    in_flight = 0;
                end
            end else begin
                if (done) chk("unexpected_done", 64'(done), 64'd0);
                if (modeSel != 2'b11) chk("unexpected_mode", 64'(modeSel), 64'd3);
            end
            if (cmdValid && cmdReady) begin
                if (sb.size() == 0 || in_flight) begin
                    chk("spurious_accept", 64'(1), 64'(0));
                end else begin
                    in_flight = 1;
                    lat = 0;
                    mode_cnt = 0;
                end
            end
        end
    end

    // Called at posedge+1 with the controller idle.
    task automatic run_cmd(input int op, input int n, input int fill, input logic [35:0] data,
                           input int abort_k, input bit hold);
        exp_t e;
        int shifts;
        int hold_cycles;
        bit ok;
        shifts = (op == 1 || op == 2) ? ((abort_k > 0) ? abort_k : n) : 0;
        e.mode = (op == 0) ? 0 : (op == 1) ? 1 : (op == 2) ? 2 : 3;
        e.fill = fill;
        e.exp_q = (op == 0) ? data : (shifts > 0) ? ref_shift(model_q, op, fill, shifts) : model_q;
        e.exp_done = (abort_k == 0);
        e.exp_lat = (abort_k > 0) ? abort_k + 1 : (op == 0) ? 2 : (op == 3 || n == 0) ? 1 : n + 1;
        e.exp_modes = (abort_k > 0) ? abort_k : (op == 0) ? 1 : (op == 3) ? 0 : n;
        hold_cycles = (abort_k > 0) ? abort_k : (op == 0) ? 1 : (op == 3 || n == 0) ? 0 : n;
        sb.push_back(e);
        model_q = e.exp_q;
        load_data = data;
        cmdOp = 2'(op);
        cmdCount = 6'(n);
        cmdFill = 2'(fill);
        cmdValid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmdReady) begin ok = 1; break; end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        if (hold) begin
            cmdOp = 2'($urandom_range(3, 0));
            cmdFill = 2'($urandom_range(3, 0));
            cmdCount = 6'($urandom_range(63, 0));
        end else begin
            cmdValid = 1'b0;
        end
        if (abort_k > 0) begin
            repeat (abort_k - 1) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            cmdValid = 1'b0;
        end else if (hold) begin
            repeat (hold_cycles) @(posedge clk);
            #1 cmdValid = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && cmdReady) begin ok = 1; break; end
        end
        chk("idle_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r64;
        int op, n, fill, k;
        bit hold;
        #1;
        chk("reset_mode", 64'(modeSel), 64'd3);
        chk("reset_ready_busy_done", 64'({cmdReady, busy, done}), 64'(3'b100));
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        @(posedge clk); #1;

        run_cmd(0, 0, 0, 36'h123456789, 0, 0);
        chk("load_q", 64'(q), 64'h123456789);
        run_cmd(0, 0, 0, 36'h800000000, 0, 0);
        run_cmd(1, 4, 0, 36'd0, 0, 0);
        chk("shl4_zero_q", 64'(q), 64'h080000000);
        run_cmd(0, 0, 0, 36'h800000000, 0, 0);
        run_cmd(1, 3, 2, 36'd0, 0, 0);
        chk("shl3_sign_q", 64'(q), 64'hF00000000);
        run_cmd(0, 0, 0, 36'h800000001, 0, 0);
        run_cmd(2, 1, 3, 36'd0, 0, 0);
        chk("shr1_rot_q", 64'(q), 64'h000000003);
        run_cmd(2, 36, 3, 36'd0, 0, 0);
        chk("shr36_rot_q", 64'(q), 64'h000000003);
        run_cmd(3, 5, 1, 36'd0, 0, 0);
        run_cmd(1, 0, 1, 36'd0, 0, 1);
        chk("nop_shl0_q", 64'(q), 64'h000000003);
        run_cmd(0, 0, 0, 36'd0, 0, 0);
        run_cmd(2, 10, 1, 36'd0, 3, 1);
        chk("shr10_abort3_q", 64'(q), 64'h000000007);

        // Reset asserted in the middle of a long shift.
        sb.push_back('{mode: 1, fill: 0, exp_q: 36'd0, exp_done: 1'b1, exp_lat: 21, exp_modes: 20});
        cmdOp = 2'd1; cmdCount = 6'd20; cmdFill = 2'd0; cmdValid = 1'b1;
        @(posedge clk); #1 cmdValid = 1'b0;
        repeat (5) @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        chk("midreset_mode", 64'(modeSel), 64'd3);
        chk("midreset_ready_busy_done", 64'({cmdReady, busy, done}), 64'(3'b100));
        chk("midreset_fills", 64'({d0Fill, d3Fill}), 64'd0);
        @(negedge clk);
        @(posedge clk); #1 resetN = 1'b1;
        @(posedge clk); #1;

        r64 = {$urandom, $urandom};
        run_cmd(0, 0, 0, r64[35:0], 0, 0);
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(3, 0));
            n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(63, 36)) : int'($urandom_range(40, 0));
            fill = int'($urandom_range(3, 0));
            k = 0;
            if ((op == 1 || op == 2) && n >= 2 && $urandom_range(3, 0) == 0)
                k = int'($urandom_range(n - 1, 1));
            hold = ($urandom_range(3, 0) == 0);
            r64 = {$urandom, $urandom};
            run_cmd(op, n, fill, r64[35:0], k, hold);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
